pipeline_stall_controller: RTL and testbench

Central freeze/flush sequencer for the 5-stage MIPS pipeline. It merges three inputs into per-stage pipeline-register controls:
- the hazard-detection unit's stall request
- the EXE-stage branch-taken flag
- multi-cycle data-memory accesses

It owns the memory wait-state FSM and counter, and keeps stall/flush performance counters.

---
 rtl/pipeline_ctrl_pkg.sv | 26 ++
 rtl/mem_wait_counter.sv | 45 ++++
 rtl/pipeline_stall_controller.sv | 154 +++++++++++++++
 tb/tb_pipeline_stall_controller.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared types and constants for the pipeline stall controller
// Purpose: FSM state encoding, memory wait-counter width, control-bundle bit indices.
// Ports: none (package).
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_DONE = 2'd2
  } ctl_state_e;

  localparam int MEM_CNT_W = 4;

  // Bit positions inside the per-cycle control bundle driven by the top.
  localparam int CTL_PC_FREEZE      = 0;
  localparam int CTL_IF_ID_FREEZE   = 1;
  localparam int CTL_IF_ID_FLUSH    = 2;
  localparam int CTL_ID_EXE_FREEZE  = 3;
  localparam int CTL_ID_EXE_FLUSH   = 4;
  localparam int CTL_EXE_MEM_FREEZE = 5;
  localparam int CTL_MEM_WB_FREEZE  = 6;
  localparam int CTL_MEM_START      = 7;
  localparam int CTL_MEM_DONE       = 8;
  localparam int CTL_W              = 9;

endpackage

// File: rtl/mem_wait_counter.sv
// rtl/mem_wait_counter.sv - loadable down-counter timing data-memory wait states
// Purpose: holds the remaining MEM_WAIT cycles of a data-memory access.
// Ports:
//   clk, rst     clock and synchronous active-high reset (clears count)
//   load         load load_val this cycle (has priority over dec)
//   load_val     value to load
//   dec          decrement by one (saturates at zero)
//   cnt          current count
//   zero         count is zero
module mem_wait_counter
  import pipeline_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [MEM_CNT_W-1:0] load_val,
  input  logic                 dec,
  output logic [MEM_CNT_W-1:0] cnt,
  output logic                 zero
);

  logic [MEM_CNT_W-1:0] cnt_q;
  logic [MEM_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - freeze/flush sequencer for the 5-stage pipeline
// Purpose: merges hazard stall, branch flush and multi-cycle data-memory waits into
//   per-stage pipeline-register freeze/flush controls; counts stall cycles and flushes.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   hazard_detected               RAW stall request from ID
//   branch_taken                  branch resolved taken in EXE
//   mem_r_en, mem_w_en            MEM-stage data-memory read/write
//   pc_freeze .. mem_wb_freeze    per-register hold controls
//   if_id_flush, id_exe_flush     per-register bubble controls
//   mem_start, mem_done           memory access launch pulse / result-valid cycle
//   stall_cycles, flush_count     wrapping performance counters
module pipeline_stall_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_CYCLES = 4,
  parameter int PERF_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hazard_detected,
  input  logic              branch_taken,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  output logic              pc_freeze,
  output logic              if_id_freeze,
  output logic              if_id_flush,
  output logic              id_exe_freeze,
  output logic              id_exe_flush,
  output logic              exe_mem_freeze,
  output logic              mem_wb_freeze,
  output logic              mem_start,
  output logic              mem_done,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_count
);

  // MEM_WAIT is entered after the start cycle and leaves one cycle after the
  // counter reads zero, so loading N-2 gives N frozen cycles in total.
  localparam logic [MEM_CNT_W-1:0] WAIT_LOAD =
    MEM_CNT_W'((MEM_WAIT_CYCLES > 1) ? (MEM_WAIT_CYCLES - 2) : 0);

  ctl_state_e        state_q, state_d;
  logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [PERF_W-1:0] flush_count_q, flush_count_d;
  logic [CTL_W-1:0]  ctl;

  logic                 mem_access;
  logic                 mem_freeze;
  logic                 branch_apply;
  logic                 hazard_apply;
  logic                 any_freeze;
  logic                 cnt_load;
  logic                 cnt_dec;
  logic                 cnt_zero;
  logic [MEM_CNT_W-1:0] cnt_val;

  mem_wait_counter u_mem_wait_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (WAIT_LOAD),
    .dec      (cnt_dec),
    .cnt      (cnt_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    ctl          = '0;
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    mem_freeze   = 1'b0;
    branch_apply = 1'b0;
    hazard_apply = 1'b0;
    any_freeze   = 1'b0;
    mem_access   = mem_r_en | mem_w_en;

    if (rst) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (mem_access) begin
            mem_freeze         = 1'b1;
            ctl[CTL_MEM_START] = 1'b1;
            if (MEM_WAIT_CYCLES == 1) begin
              state_d = MEM_DONE;
            end else begin
              state_d  = MEM_WAIT;
              cnt_load = 1'b1;
            end
          end
        end
        MEM_WAIT: begin
          mem_freeze = 1'b1;
          if (cnt_zero) begin
            state_d = MEM_DONE;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        MEM_DONE: begin
          // Same instruction still sits in MEM: mem_access must not retrigger.
          ctl[CTL_MEM_DONE] = 1'b1;
          state_d           = RUN;
        end
        default: state_d = RUN;
      endcase

      // Memory freeze beats branch flush beats hazard stall; a branch squashes
      // the stalled instruction so the hazard is dropped.
      branch_apply = !mem_freeze && branch_taken;
      hazard_apply = !mem_freeze && !branch_taken && hazard_detected;
    end

    ctl[CTL_PC_FREEZE]      = mem_freeze | hazard_apply;
    ctl[CTL_IF_ID_FREEZE]   = mem_freeze | hazard_apply;
    ctl[CTL_IF_ID_FLUSH]    = branch_apply;
    ctl[CTL_ID_EXE_FREEZE]  = mem_freeze;
    ctl[CTL_ID_EXE_FLUSH]   = branch_apply | hazard_apply;
    ctl[CTL_EXE_MEM_FREEZE] = mem_freeze;
    ctl[CTL_MEM_WB_FREEZE]  = mem_freeze;
    any_freeze              = mem_freeze | hazard_apply;

    stall_cycles_d = stall_cycles_q + {{(PERF_W-1){1'b0}}, any_freeze};
    flush_count_d  = flush_count_q + {{(PERF_W-1){1'b0}}, branch_apply};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign pc_freeze      = ctl[CTL_PC_FREEZE];
  assign if_id_freeze   = ctl[CTL_IF_ID_FREEZE];
  assign if_id_flush    = ctl[CTL_IF_ID_FLUSH];
  assign id_exe_freeze  = ctl[CTL_ID_EXE_FREEZE];
  assign id_exe_flush   = ctl[CTL_ID_EXE_FLUSH];
  assign exe_mem_freeze = ctl[CTL_EXE_MEM_FREEZE];
  assign mem_wb_freeze  = ctl[CTL_MEM_WB_FREEZE];
  assign mem_start      = ctl[CTL_MEM_START];
  assign mem_done       = ctl[CTL_MEM_DONE];
  assign stall_cycles   = stall_cycles_q;
  assign flush_count    = flush_count_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb/tb_pipeline_stall_controller.sv - self-checking bench for pipeline_stall_controller
module tb_pipeline_stall_controller;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hazard_detected = 1'b0;
  logic        branch_taken = 1'b0;
  logic        mem_r_en = 1'b0;
  logic        mem_w_en = 1'b0;
  logic        pc_freeze, if_id_freeze, if_id_flush, id_exe_freeze, id_exe_flush;
  logic        exe_mem_freeze, mem_wb_freeze, mem_start, mem_done;
  logic [31:0] stall_cycles, flush_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  pipeline_stall_controller #(.MEM_WAIT_CYCLES(N), .PERF_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .hazard_detected (hazard_detected),
    .branch_taken    (branch_taken),
    .mem_r_en        (mem_r_en),
    .mem_w_en        (mem_w_en),
    .pc_freeze       (pc_freeze),
    .if_id_freeze    (if_id_freeze),
    .if_id_flush     (if_id_flush),
    .id_exe_freeze   (id_exe_freeze),
    .id_exe_flush    (id_exe_flush),
    .exe_mem_freeze  (exe_mem_freeze),
    .mem_wb_freeze   (mem_wb_freeze),
    .mem_start       (mem_start),
    .mem_done        (mem_done),
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [8:0] dut_vec();
    return {pc_freeze, if_id_freeze, if_id_flush, id_exe_freeze, id_exe_flush,
            exe_mem_freeze, mem_wb_freeze, mem_start, mem_done};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Model: an access freezes for N cycles counted down in m_rem, followed by
  // one result cycle (m_in_done) in which the branch/hazard rules apply.
  int          m_rem = 0;
  bit          m_in_done = 0;
  bit          m_valid = 0;
  logic [31:0] m_stall = 0;
  logic [31:0] m_flush = 0;
  bit          fz, st, dn, br, hz;
  logic [8:0]  exp_vec;

  always @(negedge clk) begin
    fz = 0; st = 0; dn = 0; br = 0; hz = 0;
    if (rst) begin
      chk("rst_outputs", {23'd0, dut_vec()}, 32'd0);
      m_rem = 0; m_in_done = 0; m_stall = 0; m_flush = 0; m_valid = 1;
    end else if (m_valid) begin
      chk("stall_cycles", stall_cycles, m_stall);
      chk("flush_count", flush_count, m_flush);
      if (m_in_done) begin
        dn = 1; br = branch_taken; hz = hazard_detected && !branch_taken;
        m_in_done = 0;
      end else if (m_rem > 0) begin
        fz = 1; m_rem--;
        if (m_rem == 0) m_in_done = 1;
      end else if (mem_r_en || mem_w_en) begin
        fz = 1; st = 1; m_rem = N - 1;
        if (m_rem == 0) m_in_done = 1;
      end else begin
        br = branch_taken; hz = hazard_detected && !branch_taken;
      end
      exp_vec = {fz | hz, fz | hz, br, fz, br | hz, fz, fz, st, dn};
      chk("ctl_vector", {23'd0, dut_vec()}, {23'd0, exp_vec});
      m_stall = m_stall + ((fz | hz) ? 32'd1 : 32'd0);
      m_flush = m_flush + (br ? 32'd1 : 32'd0);
    end
  end

  // Apply inputs just after a rising edge, then sample at the following falling edge.
  task automatic step(input bit r, input bit h, input bit b, input bit rd, input bit wr);
    @(posedge clk);
    #1;
    rst = r; hazard_detected = h; branch_taken = b; mem_r_en = rd; mem_w_en = wr;
    @(negedge clk);
    #1;
  endtask

  initial begin
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1);
    chk("lit_rst_pc_freeze", {31'd0, pc_freeze}, 32'd0);
    chk("lit_rst_mem_start", {31'd0, mem_start}, 32'd0);

    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("lit_idle_stall", stall_cycles, 32'd0);
    chk("lit_idle_flush", flush_count, 32'd0);
    chk("lit_idle_freeze", {31'd0, pc_freeze}, 32'd0);

    // Read access, mem_r_en held through the result cycle.
    step(0, 0, 0, 1, 0);
    chk("lit_t0_start", {31'd0, mem_start}, 32'd1);
    chk("lit_t0_memwb", {31'd0, mem_wb_freeze}, 32'd1);
    for (int i = 1; i < N; i++) begin
      step(0, 0, 0, 1, 0);
      chk("lit_wait_start", {31'd0, mem_start}, 32'd0);
      chk("lit_wait_exemem", {31'd0, exe_mem_freeze}, 32'd1);
    end
    step(0, 0, 0, 1, 0);
    chk("lit_done", {31'd0, mem_done}, 32'd1);
    chk("lit_done_pc", {31'd0, pc_freeze}, 32'd0);
    chk("lit_done_noretrig", {31'd0, mem_start}, 32'd0);
    step(0, 0, 0, 0, 0);
    chk("lit_mem_stall4", stall_cycles, 32'd4);

    // Single-cycle hazard.
    step(0, 1, 0, 0, 0);
    chk("lit_hz_pc", {31'd0, pc_freeze}, 32'd1);
    chk("lit_hz_ifid", {31'd0, if_id_freeze}, 32'd1);
    chk("lit_hz_idexe_flush", {31'd0, id_exe_flush}, 32'd1);
    chk("lit_hz_exemem", {31'd0, exe_mem_freeze}, 32'd0);
    step(0, 0, 0, 0, 0);
    chk("lit_hz_stall5", stall_cycles, 32'd5);

    // Branch and hazard together: branch wins.
    step(0, 1, 1, 0, 0);
    chk("lit_br_ifid_flush", {31'd0, if_id_flush}, 32'd1);
    chk("lit_br_idexe_flush", {31'd0, id_exe_flush}, 32'd1);
    chk("lit_br_pc", {31'd0, pc_freeze}, 32'd0);
    step(0, 0, 0, 0, 0);
    chk("lit_br_flush1", flush_count, 32'd1);

    // Branch held across a write access: applied only in the result cycle.
    for (int i = 0; i < N; i++) begin
      step(0, 0, 1, 0, 1);
      chk("lit_membr_noflush", {31'd0, if_id_flush}, 32'd0);
    end
    step(0, 0, 1, 0, 1);
    chk("lit_membr_flush", {31'd0, if_id_flush}, 32'd1);
    chk("lit_membr_done", {31'd0, mem_done}, 32'd1);
    step(0, 0, 0, 0, 0);
    chk("lit_membr_flush2", flush_count, 32'd2);
    chk("lit_membr_stall9", stall_cycles, 32'd9);

    // Reset at t0+2 of an access.
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    chk("lit_midrst_freeze", {31'd0, pc_freeze}, 32'd0);
    chk("lit_midrst_done", {31'd0, mem_done}, 32'd0);
    for (int i = 0; i < N; i++) begin
      step(0, 0, 0, 0, 0);
      chk("lit_after_rst_done", {31'd0, mem_done}, 32'd0);
    end
    chk("lit_after_rst_stall", stall_cycles, 32'd0);
    chk("lit_after_rst_flush", flush_count, 32'd0);
    step(0, 0, 0, 0, 1);
    chk("lit_after_rst_start", {31'd0, mem_start}, 32'd1);
    for (int i = 0; i < N + 2; i++) step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
